// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin sequencer for the 64 x 32 single-port
// data RAM. One transaction at a time: IDLE -> ACCESS (grant, RAM driven)
// -> IDLE for writes, or -> RESP (read data returned) -> IDLE for reads.
module ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_dina,
  input  logic [DW-1:0] ram_douta
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic last;    // most recent grantee (0 = m0, 1 = m1)
  logic owner;   // master owning the transaction in flight
  logic we_reg;  // registered write flag of the transaction in flight
  logic any_req;
  logic win;

  assign any_req = m0_req | m1_req;
  // On a tie the master that was not granted last wins; a lone requester wins.
  assign win = (m0_req & m1_req) ? ~last : m1_req;

  // State register; reset drops ACCESS/RESP at once so no write or rvalid leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request and update the round-robin pointer on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      we_reg   <= 1'b0;
      ram_addr <= '0;
      ram_dina <= '0;
    end else if (state == IDLE && any_req) begin
      last     <= win;
      owner    <= win;
      we_reg   <= win ? m1_we : m0_we;
      ram_addr <= win ? m1_addr : m0_addr;
      ram_dina <= win ? m1_wdata : m0_wdata;
    end
  end

  // Next-state and per-state outputs (grant, write enable, read strobe/data).
  always_comb begin
    state_next = state;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    ram_wea    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        m0_gnt     = ~owner;
        m1_gnt     = owner;
        ram_wea    = we_reg;
        state_next = we_reg ? IDLE : RESP;
      end
      RESP: begin
        m0_rvalid  = ~owner;
        m1_rvalid  = owner;
        m0_rdata   = owner ? '0 : ram_douta;
        m1_rdata   = owner ? ram_douta : '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
